pp_uart_dispatch: RTL and testbench



---
 rtl/pp_uart_dispatch_pkg.sv | 15 +
 rtl/pp_beat_fifo.sv | 54 +++++
 rtl/pp_uart_dispatch.sv | 212 +++++++++++++++++++++
 tb/tb_pp_uart_dispatch.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pp_uart_dispatch_pkg.sv
`timescale 1ns/1ps
// Shared constants and serializer state encoding for the periplex UART dispatch slice.
package pp_uart_dispatch_pkg;

  localparam int unsigned PP_TOTAL_UART = 4;
  localparam int unsigned PP_HDR_BYTES  = 4;
  localparam int unsigned PP_CONT_BYTES = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_CFG  = 2'd2
  } pp_ser_state_e;

endpackage

// File: rtl/pp_beat_fifo.sv
`timescale 1ns/1ps
// Circular beat queue with wrapping pointers and an occupancy count; DEPTH must be a power of two >= 2.
module pp_beat_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 59,
  localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty,
  output logic [CW-1:0]    o_count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_wr;
  logic             w_rd;

  assign w_rd = i_pop && (r_count != '0);
  // A full queue still accepts a push when the head leaves in the same cycle.
  assign w_wr = i_push && (!o_full || w_rd);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_wr && !w_rd)      r_count <= r_count + CW'(1);
      else if (w_rd && !w_wr) r_count <= r_count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= i_wdata;
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

endmodule

// File: rtl/pp_uart_dispatch.sv
`timescale 1ns/1ps
// Queues UART-group beats from the periplex decoder and serializes them as per-channel bytes or config strobes.
// Build option: PP_UART_DISPATCH_DROPCNT_EN adds a saturating dropped-beat counter on drop_cnt.
module pp_uart_dispatch
  import pp_uart_dispatch_pkg::*;
#(
  parameter int unsigned TOTAL_UART  = PP_TOTAL_UART,
  parameter int unsigned SEL_WIDTH   = 7,
  parameter int unsigned LEN_WIDTH   = 7,
  parameter int unsigned VALUE_WIDTH = 48,
  parameter int unsigned DEPTH       = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   uart_grp_en,
  input  logic [SEL_WIDTH-1:0]   slv_sel,
  input  logic                   cfg,
  input  logic [LEN_WIDTH-1:0]   str_len,
  input  logic [VALUE_WIDTH-1:0] value,
  output logic [TOTAL_UART-1:0]  tx_valid,
  output logic [7:0]             tx_data,
  input  logic [TOTAL_UART-1:0]  tx_ready,
  output logic                   cfg_valid,
  output logic [SEL_WIDTH-1:0]   cfg_sel,
  output logic [31:0]            cfg_data,
  output logic                   overflow,
  output logic                   busy,
  output logic [7:0]             drop_cnt
);

  localparam int unsigned EW = 1 + SEL_WIDTH + 3 + VALUE_WIDTH;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic                   r_in_msg;
  logic [LEN_WIDTH-1:0]   r_remaining;
  logic                   w_push;
  logic [2:0]             w_nbytes;
  logic [VALUE_WIDTH-1:0] w_beat_data;
  logic                   w_in_msg_nx;
  logic [LEN_WIDTH-1:0]   w_rem_nx;

  logic [EW-1:0]          w_rdata;
  logic                   w_full;
  logic                   w_empty;
  logic [CW-1:0]          w_count;
  logic                   w_pop;
  logic                   w_push_ok;
  logic                   w_drop;
  logic [CW-1:0]          w_cnt_nx;

  pp_ser_state_e          r_state, w_state_nx;
  logic [SEL_WIDTH-1:0]   r_sel, w_sel_nx;
  logic [2:0]             r_nb, w_nb_nx;
  logic [VALUE_WIDTH-1:0] r_data, w_data_nx;
  logic [2:0]             r_idx, w_idx_nx;
  logic                   w_sel_ready;

  logic [TOTAL_UART-1:0]  r_tx_valid, w_tx_valid_nx;
  logic [7:0]             r_tx_data, w_tx_data_nx;
  logic                   r_cfg_valid;
  logic [SEL_WIDTH-1:0]   r_cfg_sel, w_cfg_sel_nx;
  logic [31:0]            r_cfg_data, w_cfg_data_nx;
  logic                   r_overflow;
  logic                   r_busy;

  // Beat classification: config, message header, or continuation of the current message.
  always_comb begin
    w_push      = 1'b0;
    w_nbytes    = '0;
    w_beat_data = '0;
    w_in_msg_nx = r_in_msg;
    w_rem_nx    = r_remaining;
    if (uart_grp_en && (32'(slv_sel) < 32'(TOTAL_UART))) begin
      if (cfg) begin
        w_push      = 1'b1;
        w_beat_data = value;
      end else if (!r_in_msg) begin
        w_nbytes    = (str_len > LEN_WIDTH'(PP_HDR_BYTES)) ? 3'(PP_HDR_BYTES) : 3'(str_len);
        w_beat_data = VALUE_WIDTH'(value[31:0]);
        w_rem_nx    = str_len - LEN_WIDTH'(w_nbytes);
        w_in_msg_nx = (w_rem_nx != '0);
        w_push      = (str_len != '0);
      end else begin
        w_nbytes    = (r_remaining > LEN_WIDTH'(PP_CONT_BYTES)) ? 3'(PP_CONT_BYTES) : 3'(r_remaining);
        w_beat_data = value;
        w_rem_nx    = r_remaining - LEN_WIDTH'(w_nbytes);
        w_in_msg_nx = (w_rem_nx != '0);
        w_push      = 1'b1;
      end
    end
  end

  assign w_push_ok = w_push && (!w_full || w_pop);
  assign w_drop    = w_push && w_full && !w_pop;
  assign w_cnt_nx  = w_count + CW'(w_push_ok) - CW'(w_pop);

  pp_beat_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata ({cfg, slv_sel, w_nbytes, w_beat_data}),
    .o_rdata (w_rdata),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign w_sel_ready = |(tx_ready & (TOTAL_UART'(1) << r_sel));

  // Serializer next state plus the registered output values it implies.
  always_comb begin
    w_state_nx = r_state;
    w_sel_nx   = r_sel;
    w_nb_nx    = r_nb;
    w_data_nx  = r_data;
    w_idx_nx   = r_idx;
    w_pop      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop      = 1'b1;
          w_sel_nx   = w_rdata[EW-2 -: SEL_WIDTH];
          w_nb_nx    = w_rdata[VALUE_WIDTH +: 3];
          w_data_nx  = w_rdata[VALUE_WIDTH-1:0];
          w_idx_nx   = '0;
          w_state_nx = w_rdata[EW-1] ? ST_CFG : ST_SEND;
        end
      end
      ST_SEND: begin
        if (w_sel_ready) begin
          if (r_idx == r_nb - 3'd1) w_state_nx = ST_IDLE;
          else                      w_idx_nx   = r_idx + 3'd1;
        end
      end
      ST_CFG:  w_state_nx = ST_IDLE;
      default: w_state_nx = ST_IDLE;
    endcase

    w_tx_valid_nx = '0;
    w_tx_data_nx  = '0;
    w_cfg_sel_nx  = '0;
    w_cfg_data_nx = '0;
    if (w_state_nx == ST_SEND) begin
      w_tx_valid_nx = TOTAL_UART'(1) << w_sel_nx;
      w_tx_data_nx  = w_data_nx[{w_idx_nx, 3'b000} +: 8];
    end
    if (w_state_nx == ST_CFG) begin
      w_cfg_sel_nx  = w_sel_nx;
      w_cfg_data_nx = w_data_nx[31:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_msg    <= 1'b0;
      r_remaining <= '0;
      r_state     <= ST_IDLE;
      r_sel       <= '0;
      r_nb        <= '0;
      r_data      <= '0;
      r_idx       <= '0;
      r_tx_valid  <= '0;
      r_tx_data   <= '0;
      r_cfg_valid <= 1'b0;
      r_cfg_sel   <= '0;
      r_cfg_data  <= '0;
      r_overflow  <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_in_msg    <= w_in_msg_nx;
      r_remaining <= w_rem_nx;
      r_state     <= w_state_nx;
      r_sel       <= w_sel_nx;
      r_nb        <= w_nb_nx;
      r_data      <= w_data_nx;
      r_idx       <= w_idx_nx;
      r_tx_valid  <= w_tx_valid_nx;
      r_tx_data   <= w_tx_data_nx;
      r_cfg_valid <= (w_state_nx == ST_CFG);
      r_cfg_sel   <= w_cfg_sel_nx;
      r_cfg_data  <= w_cfg_data_nx;
      r_busy      <= (w_cnt_nx != '0) || (w_state_nx != ST_IDLE);
      if (w_drop) r_overflow <= 1'b1;
    end
  end

`ifdef PP_UART_DISPATCH_DROPCNT_EN
  logic [7:0] r_drop_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                            r_drop_cnt <= '0;
    else if (w_drop && r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 8'd1;
  end

  assign drop_cnt = r_drop_cnt;
`else
  assign drop_cnt = 8'd0;
`endif

  assign tx_valid  = r_tx_valid;
  assign tx_data   = r_tx_data;
  assign cfg_valid = r_cfg_valid;
  assign cfg_sel   = r_cfg_sel;
  assign cfg_data  = r_cfg_data;
  assign overflow  = r_overflow;
  assign busy      = r_busy;

endmodule

// File: tb/tb_pp_uart_dispatch.sv
`timescale 1ns/1ps
// Scoreboard bench for pp_uart_dispatch; follows PP_UART_DISPATCH_DROPCNT_EN like the design.
module tb_pp_uart_dispatch;
  import pp_uart_dispatch_pkg::*;

  localparam int unsigned NU = PP_TOTAL_UART;
  localparam int unsigned SW = 7;
  localparam int unsigned LW = 7;
  localparam int unsigned VW = 48;

  typedef struct packed {
    logic          is_cfg;
    logic [SW-1:0] ch;
    logic [31:0]   data;
  } ev_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          uart_grp_en;
  logic [SW-1:0] slv_sel;
  logic          cfg;
  logic [LW-1:0] str_len;
  logic [VW-1:0] value;
  logic [NU-1:0] tx_valid;
  logic [7:0]    tx_data;
  logic [NU-1:0] tx_ready;
  logic          cfg_valid;
  logic [SW-1:0] cfg_sel;
  logic [31:0]   cfg_data;
  logic          overflow;
  logic          busy;
  logic [7:0]    drop_cnt;

  ev_t exp_q[$];
  int  checks;
  int  errors;

  pp_uart_dispatch dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .uart_grp_en (uart_grp_en),
    .slv_sel     (slv_sel),
    .cfg         (cfg),
    .str_len     (str_len),
    .value       (value),
    .tx_valid    (tx_valid),
    .tx_data     (tx_data),
    .tx_ready    (tx_ready),
    .cfg_valid   (cfg_valid),
    .cfg_sel     (cfg_sel),
    .cfg_data    (cfg_data),
    .overflow    (overflow),
    .busy        (busy),
    .drop_cnt    (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void exp_tx(input int ch, input logic [7:0] b);
    exp_q.push_back({1'b0, SW'(ch), 24'h0, b});
  endfunction

  function automatic void exp_cfg(input int ch, input logic [31:0] d);
    exp_q.push_back({1'b1, SW'(ch), d});
  endfunction

  task automatic compare_pop(input ev_t got);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_output: got %0h expected nothing at %0t", got, $time);
    end else begin
      e = exp_q.pop_front();
      chk("scoreboard", 64'(got), 64'(e));
    end
  endtask

  // Observes accepted bytes and config strobes; also checks that a stalled byte stays put.
  task automatic monitor();
    logic          hold = 1'b0;
    logic          prev_cfg = 1'b0;
    logic [NU-1:0] prev_v = '0;
    logic [7:0]    prev_d = '0;
    int            ch;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold     = 1'b0;
        prev_cfg = 1'b0;
      end else begin
        if (tx_valid != '0) begin
          chk("tx_onehot", 64'($onehot(tx_valid)), 64'(1));
          if (hold) begin
            chk("hold_valid", 64'(tx_valid), 64'(prev_v));
            chk("hold_data", 64'(tx_data), 64'(prev_d));
          end
          if ((tx_valid & tx_ready) != '0) begin
            ch = 0;
            for (int i = 0; i < NU; i++) if (tx_valid[i]) ch = i;
            compare_pop({1'b0, SW'(ch), 24'h0, tx_data});
            hold = 1'b0;
          end else begin
            hold = 1'b1;
          end
          prev_v = tx_valid;
          prev_d = tx_data;
        end else begin
          hold = 1'b0;
        end
        if (cfg_valid) begin
          chk("cfg_single_cycle", 64'(prev_cfg), 64'(0));
          chk("cfg_no_tx", 64'(tx_valid), 64'(0));
          compare_pop({1'b1, cfg_sel, cfg_data});
        end
        prev_cfg = cfg_valid;
      end
    end
  endtask

  task automatic send_beat(input logic c, input logic [SW-1:0] s, input logic [LW-1:0] l,
                           input logic [VW-1:0] v);
    uart_grp_en = 1'b1;
    cfg         = c;
    slv_sel     = s;
    str_len     = l;
    value       = v;
    @(posedge clk);
    #1;
    uart_grp_en = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 300) begin
      step();
      n++;
    end
    chk(name, 64'(busy), 64'(0));
  endtask

  initial begin
    int n;
    checks      = 0;
    errors      = 0;
    rst_n       = 1'b0;
    uart_grp_en = 1'b0;
    slv_sel     = '0;
    cfg         = 1'b0;
    str_len     = '0;
    value       = '0;
    tx_ready    = '0;

    fork
      monitor();
    join_none

    repeat (2) @(posedge clk);
    #1;
    chk("rst_tx_valid", 64'(tx_valid), 64'(0));
    chk("rst_tx_data", 64'(tx_data), 64'(0));
    chk("rst_cfg_valid", 64'(cfg_valid), 64'(0));
    chk("rst_cfg_sel", 64'(cfg_sel), 64'(0));
    chk("rst_cfg_data", 64'(cfg_data), 64'(0));
    chk("rst_overflow", 64'(overflow), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_drop_cnt", 64'(drop_cnt), 64'(0));
    rst_n = 1'b1;
    step();

    // Parallel write: 3 bytes on channel 1 with exact latency.
    tx_ready = '1;
    exp_tx(1, 8'hAA); exp_tx(1, 8'hBB); exp_tx(1, 8'hCC);
    send_beat(1'b0, 7'd1, 7'd3, 48'h0000_00CC_BBAA);
    chk("lat_no_valid_yet", 64'(tx_valid), 64'(0));
    chk("lat_busy", 64'(busy), 64'(1));
    step();
    chk("lat_first_valid", 64'(tx_valid), 64'(NU'(2)));
    chk("lat_first_data", 64'(tx_data), 64'(8'hAA));
    step();
    step();
    chk("par_busy_last", 64'(busy), 64'(1));
    step();
    chk("par_busy_drop", 64'(busy), 64'(0));
    chk("par_valid_drop", 64'(tx_valid), 64'(0));

    // Serial 13-byte message over three beats.
    for (int i = 0; i < 4; i++) exp_tx(0, 8'(8'h11 * (i + 1)));
    exp_tx(0, 8'h55); exp_tx(0, 8'h66); exp_tx(0, 8'h77);
    exp_tx(0, 8'h88); exp_tx(0, 8'h99); exp_tx(0, 8'hAA);
    exp_tx(0, 8'hCC); exp_tx(0, 8'hDD); exp_tx(0, 8'hEE);
    send_beat(1'b0, 7'd0, 7'd13, 48'hFFFF_4433_2211);
    send_beat(1'b0, 7'd0, 7'd0, 48'hAA99_8877_6655);
    send_beat(1'b0, 7'd0, 7'd0, 48'h0000_00EE_DDCC);
    wait_idle("serial_idle");

    // Config beat.
    exp_cfg(2, 32'h0001_C200);
    send_beat(1'b1, 7'd2, 7'd0, 48'h0000_0001_C200);
    chk("cfg_not_yet", 64'(cfg_valid), 64'(0));
    step();
    chk("cfg_valid", 64'(cfg_valid), 64'(1));
    chk("cfg_sel", 64'(cfg_sel), 64'(2));
    chk("cfg_data", 64'(cfg_data), 64'(32'h0001_C200));
    chk("cfg_tx_quiet", 64'(tx_valid), 64'(0));
    step();
    chk("cfg_strobe_end", 64'(cfg_valid), 64'(0));
    chk("cfg_busy_end", 64'(busy), 64'(0));

    // Ordering of mixed payload/config, then ignored beats.
    exp_tx(3, 8'hEF); exp_tx(3, 8'hBE);
    exp_cfg(1, 32'h1234_5678);
    exp_tx(0, 8'h5A);
    send_beat(1'b0, 7'd3, 7'd2, 48'h0000_0000_BEEF);
    send_beat(1'b1, 7'd1, 7'd0, 48'h0000_1234_5678);
    send_beat(1'b0, 7'd0, 7'd1, 48'h0000_0000_005A);
    wait_idle("order_idle");
    send_beat(1'b0, 7'd4, 7'd3, 48'h0000_0033_2211);
    send_beat(1'b0, 7'd0, 7'd0, 48'h0000_0000_0099);
    step();
    chk("ignored_beats_idle", 64'(busy), 64'(0));
    exp_tx(0, 8'h77);
    send_beat(1'b0, 7'd0, 7'd1, 48'hFFFF_FFFF_FF77);
    wait_idle("after_ignored_idle");

    // Overflow: six single-byte headers against a stalled channel.
    tx_ready = '0;
    for (int i = 1; i <= 5; i++) exp_tx(3, 8'(i));
    for (int i = 1; i <= 6; i++) begin
      send_beat(1'b0, 7'd3, 7'd1, 48'(i));
      if (i == 5) chk("ovf_before_drop", 64'(overflow), 64'(0));
    end
    chk("ovf_set", 64'(overflow), 64'(1));
`ifdef PP_UART_DISPATCH_DROPCNT_EN
    chk("ovf_drop_cnt", 64'(drop_cnt), 64'(1));
`else
    chk("ovf_drop_cnt", 64'(drop_cnt), 64'(0));
`endif
    tx_ready = '1;
    wait_idle("ovf_drain_idle");
    chk("ovf_sticky", 64'(overflow), 64'(1));

    // Backpressure: toggle the selected channel's ready, others held high.
    tx_ready = NU'(4'b1011);
    for (int i = 0; i < 4; i++) exp_tx(2, 8'(8'hA1 + 8'h11 * i));
    send_beat(1'b0, 7'd2, 7'd4, 48'h0000_D4C3_B2A1);
    n = 0;
    while (busy && n < 60) begin
      step();
      tx_ready[2] = ~tx_ready[2];
      n++;
    end
    chk("bp_idle", 64'(busy), 64'(0));

    // Reset in the middle of a message, then a fresh header.
    tx_ready = '0;
    exp_tx(1, 8'h0A); exp_tx(1, 8'h0B);
    send_beat(1'b0, 7'd1, 7'd8, 48'h0000_0D0C_0B0A);
    step();
    chk("rstmid_first", 64'(tx_data), 64'(8'h0A));
    tx_ready = '1;
    step();
    step();
    tx_ready = '0;
    chk("rstmid_byte2", 64'(tx_data), 64'(8'h0C));
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstmid_tx_valid", 64'(tx_valid), 64'(0));
    chk("rstmid_tx_data", 64'(tx_data), 64'(0));
    chk("rstmid_busy", 64'(busy), 64'(0));
    chk("rstmid_overflow", 64'(overflow), 64'(0));
    chk("rstmid_drop_cnt", 64'(drop_cnt), 64'(0));
    step();
    rst_n    = 1'b1;
    tx_ready = '1;
    step();
    exp_tx(1, 8'h11); exp_tx(1, 8'h22); exp_tx(1, 8'h33);
    exp_tx(1, 8'h44); exp_tx(1, 8'h55); exp_tx(1, 8'h66);
    send_beat(1'b0, 7'd1, 7'd6, 48'hFFFF_4433_2211);
    send_beat(1'b0, 7'd1, 7'd0, 48'h0000_0000_6655);
    wait_idle("post_reset_idle");

    repeat (3) step();
    chk("scoreboard_empty", 64'(exp_q.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
